// File: rtl/axi_info_pkg.sv
// Shared types for the info-register read path: read FSM states and AXI RRESP codes.
package axi_info_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_info_rd_slice.sv
// Fully registered single-outstanding AXI-Lite read slice in front of the info register bank.
// Latency: AR handshake cycle 0 -> m_axi_ARVALID cycle 1 -> s_axi_RVALID cycle 3 (zero-wait bank).
// Backpressure: one read in flight; upstream stalls on ARREADY=0; AXI_INFO_RD_SLICE_TIMEOUT_EN adds WAIT timeout + drain.
module axi_info_rd_slice
    import axi_info_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  s_axi_ARVALID,
    output logic                  s_axi_ARREADY,
    input  logic [ADDR_WIDTH-1:0] s_axi_ARADDR,
    output logic                  s_axi_RVALID,
    input  logic                  s_axi_RREADY,
    output logic [DATA_WIDTH-1:0] s_axi_RDATA,
    output logic [1:0]            s_axi_RRESP,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    input  logic                  m_axi_RVALID,
    output logic                  m_axi_RREADY,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic [1:0]            m_axi_RRESP
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("axi_info_rd_slice: TIMEOUT must be >= 2");
    end

    rd_state_t state, state_nxt;
    logic      ar_take;
    logic      rd_take;
    logic      expire;
    logic      drain;
    logic      drain_nxt;

    assign ar_take = (state == ST_IDLE) && s_axi_ARVALID && s_axi_ARREADY;
    assign rd_take = (state == ST_WAIT) && m_axi_RVALID && m_axi_RREADY;

`ifdef AXI_INFO_RD_SLICE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // A beat in the expiry cycle wins over the timeout.
    assign expire = (state == ST_WAIT) && !rd_take && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt <= '0;
        end else if (state != ST_WAIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // After a timeout the bank still owes one beat; swallow it before issuing the next address.
    always_comb begin
        drain_nxt = drain;
        if (expire) begin
            drain_nxt = 1'b1;
        end else if (drain && m_axi_RVALID && m_axi_RREADY) begin
            drain_nxt = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            drain <= 1'b0;
        end else begin
            drain <= drain_nxt;
        end
    end
`else
    assign expire    = 1'b0;
    assign drain     = 1'b0;
    assign drain_nxt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ar_take) state_nxt = ST_ADDR;
            ST_ADDR: if (m_axi_ARVALID && m_axi_ARREADY) state_nxt = ST_WAIT;
            ST_WAIT: if (rd_take || expire) state_nxt = ST_RESP;
            ST_RESP: if (s_axi_RVALID && s_axi_RREADY) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are precomputed from the next state so every port is a flop.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= ST_IDLE;
            s_axi_ARREADY <= 1'b0;
            s_axi_RVALID  <= 1'b0;
            s_axi_RDATA   <= '0;
            s_axi_RRESP   <= RESP_OKAY;
            m_axi_ARVALID <= 1'b0;
            m_axi_ARADDR  <= '0;
            m_axi_RREADY  <= 1'b0;
        end else begin
            state         <= state_nxt;
            s_axi_ARREADY <= (state_nxt == ST_IDLE);
            s_axi_RVALID  <= (state_nxt == ST_RESP);
            m_axi_ARVALID <= (state_nxt == ST_ADDR) && !drain_nxt;
            m_axi_RREADY  <= (state_nxt == ST_WAIT) || drain_nxt;
            if (ar_take) begin
                m_axi_ARADDR <= s_axi_ARADDR;
            end
            if (rd_take) begin
                s_axi_RDATA <= m_axi_RDATA;
                s_axi_RRESP <= m_axi_RRESP;
            end else if (expire) begin
                s_axi_RDATA <= '0;
                s_axi_RRESP <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_info_rd_slice.sv
// Directed bench for axi_info_rd_slice; timeout scenarios run when AXI_INFO_RD_SLICE_TIMEOUT_EN is defined.
module tb_axi_info_rd_slice;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          ap_clk;
    logic          ap_rst;
    logic          s_axi_ARVALID;
    logic          s_axi_ARREADY;
    logic [AW-1:0] s_axi_ARADDR;
    logic          s_axi_RVALID;
    logic          s_axi_RREADY;
    logic [DW-1:0] s_axi_RDATA;
    logic [1:0]    s_axi_RRESP;
    logic          m_axi_ARVALID;
    logic          m_axi_ARREADY;
    logic [AW-1:0] m_axi_ARADDR;
    logic          m_axi_RVALID;
    logic          m_axi_RREADY;
    logic [DW-1:0] m_axi_RDATA;
    logic [1:0]    m_axi_RRESP;

    int n_checks = 0;
    int n_errors = 0;

    axi_info_rd_slice #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (8)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_axi_ARVALID (s_axi_ARVALID),
        .s_axi_ARREADY (s_axi_ARREADY),
        .s_axi_ARADDR  (s_axi_ARADDR),
        .s_axi_RVALID  (s_axi_RVALID),
        .s_axi_RREADY  (s_axi_RREADY),
        .s_axi_RDATA   (s_axi_RDATA),
        .s_axi_RRESP   (s_axi_RRESP),
        .m_axi_ARVALID (m_axi_ARVALID),
        .m_axi_ARREADY (m_axi_ARREADY),
        .m_axi_ARADDR  (m_axi_ARADDR),
        .m_axi_RVALID  (m_axi_RVALID),
        .m_axi_RREADY  (m_axi_RREADY),
        .m_axi_RDATA   (m_axi_RDATA),
        .m_axi_RRESP   (m_axi_RRESP)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one AR beat in the current cycle, then advance to cycle 1 (ADDR).
    task automatic issue(input logic [AW-1:0] addr);
        s_axi_ARVALID = 1'b1;
        s_axi_ARADDR  = addr;
        step();
        s_axi_ARVALID = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] held;
        int            seen;

        ap_rst        = 1'b1;
        s_axi_ARVALID = 1'b0;
        s_axi_ARADDR  = '0;
        s_axi_RREADY  = 1'b0;
        m_axi_ARREADY = 1'b1;
        m_axi_RVALID  = 1'b0;
        m_axi_RDATA   = '0;
        m_axi_RRESP   = 2'b00;

        // Reset values and release
        step();
        step();
        check("rst_arready", s_axi_ARREADY, 0);
        check("rst_rvalid", s_axi_RVALID, 0);
        check("rst_m_arvalid", m_axi_ARVALID, 0);
        check("rst_m_rready", m_axi_RREADY, 0);
        ap_rst = 1'b0;
        check("rel_arready_before_edge", s_axi_ARREADY, 0);
        step();
        check("rel_arready", s_axi_ARREADY, 1);
        check("rel_rvalid", s_axi_RVALID, 0);

        // Zero-wait read of address 0x04
        issue(5'h04);
        check("zw_m_arvalid_c1", m_axi_ARVALID, 1);
        check("zw_m_araddr", m_axi_ARADDR, 32'h04);
        check("zw_arready_c1", s_axi_ARREADY, 0);
        step();
        check("zw_m_rready_c2", m_axi_RREADY, 1);
        check("zw_m_arvalid_c2", m_axi_ARVALID, 0);
        check("zw_rvalid_c2", s_axi_RVALID, 0);
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'h4649_4E4E;
        m_axi_RRESP  = 2'b00;
        step();
        m_axi_RVALID = 1'b0;
        m_axi_RDATA  = 32'hDEAD_BEEF;
        check("zw_rvalid_c3", s_axi_RVALID, 1);
        check("zw_rdata", s_axi_RDATA, 32'h4649_4E4E);
        check("zw_rresp", s_axi_RRESP, 2'b00);

        // Upstream backpressure for 5 cycles
        held = s_axi_RDATA;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_axi_RVALID !== 1'b1 || s_axi_RDATA !== held || s_axi_ARREADY !== 1'b0) seen++;
        end
        check("bp_stable_cycles_bad", seen, 0);
        s_axi_RREADY = 1'b1;
        step();
        check("bp_rvalid_drop", s_axi_RVALID, 0);
        check("bp_arready_back", s_axi_ARREADY, 1);

`ifdef AXI_INFO_RD_SLICE_TIMEOUT_EN
        // Silent bank: SLVERR 8 cycles after WAIT entry, late beat at cycle 12 absorbed
        issue(5'h08);
        step();
        check("to_wait_entry_rready", m_axi_RREADY, 1);
        for (int i = 0; i < 7; i++) step();
        check("to_c9_no_resp", s_axi_RVALID, 0);
        step();
        check("to_rvalid_c10", s_axi_RVALID, 1);
        check("to_rdata_zero", s_axi_RDATA, 0);
        check("to_rresp_slverr", s_axi_RRESP, 2'b10);
        check("to_drain_rready", m_axi_RREADY, 1);
        step();
        check("to_idle_c11", s_axi_ARREADY, 1);
        check("to_drain_rready_idle", m_axi_RREADY, 1);
        issue(5'h0C);
        check("dr_arvalid_held_low", m_axi_ARVALID, 0);
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'hBAD0_BAD0;
        step();
        m_axi_RVALID = 1'b0;
        check("dr_arvalid_after_drain", m_axi_ARVALID, 1);
        check("dr_rready_cleared", m_axi_RREADY, 0);
        check("dr_araddr", m_axi_ARADDR, 32'h0C);
        step();
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'h1234_5678;
        step();
        m_axi_RVALID = 1'b0;
        check("dr_next_rvalid", s_axi_RVALID, 1);
        check("dr_next_rdata", s_axi_RDATA, 32'h1234_5678);
        check("dr_next_rresp", s_axi_RRESP, 2'b00);
        step();

        // Bank beat exactly in the expiry cycle wins
        issue(5'h14);
        step();
        for (int i = 0; i < 7; i++) step();
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'hCAFE_F00D;
        step();
        m_axi_RVALID = 1'b0;
        check("ex_rvalid", s_axi_RVALID, 1);
        check("ex_rdata", s_axi_RDATA, 32'hCAFE_F00D);
        check("ex_rresp_okay", s_axi_RRESP, 2'b00);
        check("ex_no_drain", m_axi_RREADY, 0);
        step();
        check("ex_idle_no_drain", m_axi_RREADY, 0);
`else
        // Without the timeout the slice waits indefinitely
        issue(5'h08);
        step();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_RVALID !== 1'b0 || m_axi_RREADY !== 1'b1) seen++;
            step();
        end
        check("nt_waits_bad", seen, 0);
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'h0BAD_CAFE;
        m_axi_RRESP  = 2'b10;
        step();
        m_axi_RVALID = 1'b0;
        m_axi_RRESP  = 2'b00;
        check("nt_rvalid", s_axi_RVALID, 1);
        check("nt_rdata", s_axi_RDATA, 32'h0BAD_CAFE);
        check("nt_rresp_pass", s_axi_RRESP, 2'b10);
        step();
`endif

        // Reset pulse while in WAIT abandons the read
        issue(5'h10);
        step();
        check("rw_in_wait", m_axi_RREADY, 1);
        ap_rst = 1'b1;
        #1;
        check("rw_arready", s_axi_ARREADY, 0);
        check("rw_rvalid", s_axi_RVALID, 0);
        check("rw_m_arvalid", m_axi_ARVALID, 0);
        check("rw_m_rready", m_axi_RREADY, 0);
        check("rw_m_araddr", m_axi_ARADDR, 0);
        check("rw_rdata", s_axi_RDATA, 0);
        step();
        ap_rst = 1'b0;
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = 32'h5555_AAAA;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            m_axi_RVALID = 1'b0;
            if (s_axi_RVALID !== 1'b0) seen++;
        end
        check("rw_no_resp_after", seen, 0);
        check("rw_arready_back", s_axi_ARREADY, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_info_rd_slice.md
AXI_INFO_RD_SLICE -- requirements
Module: axi_info_rd_slice

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, which sets the AXI-Lite read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, which sets the read data width.
REQ-003 SHALL have parameter TIMEOUT, default 256, which sets the cycles to wait for m_axi_RVALID before a local error response (TIMEOUT >= 2).
REQ-004 SHALL have one clock and an asynchronous active-high reset, with ports as follows:
  ap_clk  in  1  clock
  ap_rst  in  1  asynchronous reset, active-high
  s_axi_ARVALID  in  1  upstream read address valid
  s_axi_ARREADY  out  1  upstream read address ready
  s_axi_ARADDR  in  ADDR_WIDTH  upstream read address
  s_axi_RVALID  out  1  upstream read data valid
  s_axi_RREADY  in  1  upstream read data ready
  s_axi_RDATA  out  DATA_WIDTH  upstream read data
  s_axi_RRESP  out  2  upstream read response
  m_axi_ARVALID  out  1  read address valid toward the info register bank
  m_axi_ARREADY  in  1  read address ready from the bank
  m_axi_ARADDR  out  ADDR_WIDTH  registered read address
  m_axi_RVALID  in  1  bank read data valid
  m_axi_RREADY  out  1  bank read data ready
  m_axi_RDATA  in  DATA_WIDTH  bank read data
  m_axi_RRESP  in  2  bank read response

Function
REQ-005 SHALL be a fully registered, single-outstanding AXI-Lite read slice that sits upstream of the info register bank; every output is driven from a flop.
REQ-006 SHALL implement the FSM IDLE -> ADDR -> WAIT -> RESP -> IDLE.
- IDLE: s_axi_ARREADY=1; on the s_axi AR handshake, capture ARADDR and go to ADDR.
- ADDR: m_axi_ARVALID=1 and held until m_axi_ARREADY; then go to WAIT.
- WAIT: m_axi_RREADY=1; on m_axi_RVALID, capture RDATA/RRESP and go to RESP.
- RESP: s_axi_RVALID=1 and held with stable data until s_axi_RREADY; then go to IDLE.
REQ-007 SHALL give minimum latency s_axi AR handshake (cycle 0) -> m_axi_ARVALID (cycle 1) -> s_axi_RVALID (cycle 3) when the bank responds with zero wait; best-case throughput is one read per 4 cycles.
REQ-008 SHALL pass RRESP through unchanged and zero-extend nothing (widths match).
REQ-009 SHALL keep a TIMEOUT counter that runs only in WAIT, clears on WAIT entry, and at count TIMEOUT-1 without m_axi_RVALID drives RESP with RDATA=0 and RRESP=2'b10 (SLVERR).
REQ-010 SHALL set a drain flag after a timeout; while it is set, m_axi_RREADY=1 in every state, and the next m_axi_RVALID beat is discarded and clears the flag.
REQ-011 SHALL hold a new read in ADDR while the drain flag is set, with m_axi_ARVALID=0, so that a late beat is never matched to a new address.
REQ-012 SHALL treat an m_axi_RVALID arriving in the same cycle the counter expires as a normal response: data wins and no timeout occurs.
REQ-013 SHALL never count time spent in ADDR toward the timeout; m_axi_ARVALID, once raised, is not withdrawn.

Reset
REQ-014 SHALL, while ap_rst=1, force state IDLE, all VALID/READY outputs to 0, RDATA/RRESP/ARADDR to 0, the counter to 0 and drain to 0.
REQ-015 SHALL raise s_axi_ARREADY in the first clock after ap_rst deasserts.
REQ-016 SHALL abandon an in-flight transaction on reset assertion mid-operation, with no response issued afterwards.

Configuration
REQ-017 SHALL, with macro AXI_INFO_RD_SLICE_TIMEOUT_EN defined, include the counter and drain logic (REQ-009..012).
REQ-018 SHALL, without that macro, omit the counter and drain logic, so that WAIT waits indefinitely and m_axi_RREADY=1 only in WAIT.

Structure
REQ-019 SHALL place the FSM state enum and the RRESP constants (OKAY=2'b00, SLVERR=2'b10) in shared package axi_info_pkg.
REQ-020 SHALL have no sub-module; the FSM and counter are inline.

Verification
REQ-021 Reset release -> s_axi_ARREADY=0 during reset and 1 one cycle after; RVALID=0.
REQ-022 AR addr 5'h04, bank zero-wait returning 32'h4649_4E4E/OKAY -> s_axi_RVALID at cycle 3 with 32'h4649_4E4E, RRESP=2'b00.
REQ-023 Upstream RREADY low for 5 cycles -> RDATA stable, s_axi_ARREADY=0 throughout, then return to IDLE.
REQ-024 (TIMEOUT_EN, TIMEOUT=8) bank silent -> SLVERR with RDATA=0 8 cycles after WAIT entry; a late bank beat at cycle 12 is absorbed; the next read returns correct data.
REQ-025 Bank m_axi_RVALID in the exact expiry cycle -> OKAY with the bank data and no drain.
REQ-026 ap_rst pulsed while in WAIT -> all outputs return to their reset values, and no s_axi_RVALID is seen afterwards.
